approx_mul_err_sweeper: RTL

Hardware error-characterisation engine for the approximate multiplier family (unsigned_int_mul and successors). On start it sweeps every operand pair (A,B) over 2^WIDTH x 2^WIDTH and drives them plus a latched configuration mask to an external multiplier instance. It compares each returned approximate product against the exact product, accounting for a parametrised DUT latency. It accumulates error count, over-estimate count, summed error distance and maximum error distance with its operands, for on-chip or FPGA characterisation without a simulator.

---
 rtl/approx_mul_err_sweeper.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/approx_mul_err_sweeper.sv
// Sweeps every operand pair through an external approximate multiplier and
// accumulates error statistics against the exact product.
module approx_mul_err_sweeper #(
   parameter int WIDTH   = 8,
   parameter int DUT_LAT = 0,
   parameter int CONF_W  = 6,
   parameter int SUM_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CONF_W-1:0]    conf_in,
   input  logic [2*WIDTH-1:0]   approx_r,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   output logic [CONF_W-1:0]    conf_out,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH:0]     err_count,
   output logic [2*WIDTH:0]     over_count,
   output logic [SUM_W-1:0]     sum_ed,
   output logic [2*WIDTH-1:0]   max_ed,
   output logic [WIDTH-1:0]     max_a,
   output logic [WIDTH-1:0]     max_b,
   output logic [1:0]           state_dbg
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = ((SUM_W > PW) ? SUM_W : PW) + 1;
   localparam int DW = $clog2(DUT_LAT + 2);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [DW-1:0]    drain_cnt;
   logic             issue;
   logic             last_issue;
   logic             flush;
   logic             tag_vld;
   logic [WIDTH-1:0] tag_a;
   logic [WIDTH-1:0] tag_b;
   logic [PW-1:0]    tag_exact;
   logic [PW-1:0]    ed;
   logic [SW-1:0]    sum_ext;

   assign issue      = (state == S_SWEEP);
   assign last_issue = issue && (&op_a) && (&op_b);
   assign flush      = abort && ((state == S_SWEEP) || (state == S_DRAIN));
   assign busy       = (state == S_SWEEP) || (state == S_DRAIN);
   assign done       = (state == S_DONE);
   assign state_dbg  = state;

   // The tag travels alongside the external multiplier so the returned
   // product is compared against the pair that produced it.
   generate
      if (DUT_LAT == 0) begin : g_comb
         assign tag_vld   = issue;
         assign tag_a     = op_a;
         assign tag_b     = op_b;
         assign tag_exact = PW'(op_a) * PW'(op_b);
      end else begin : g_pipe
         logic             pipe_vld [DUT_LAT];
         logic [WIDTH-1:0] pipe_a   [DUT_LAT];
         logic [WIDTH-1:0] pipe_b   [DUT_LAT];
         logic [PW-1:0]    pipe_x   [DUT_LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DUT_LAT; i++) begin
                  pipe_vld[i] <= 1'b0;
                  pipe_a[i]   <= '0;
                  pipe_b[i]   <= '0;
                  pipe_x[i]   <= '0;
               end
            end else begin
               pipe_vld[0] <= issue && !flush;
               pipe_a[0]   <= op_a;
               pipe_b[0]   <= op_b;
               pipe_x[0]   <= PW'(op_a) * PW'(op_b);
               for (int i = 1; i < DUT_LAT; i++) begin
                  pipe_vld[i] <= pipe_vld[i-1] && !flush;
                  pipe_a[i]   <= pipe_a[i-1];
                  pipe_b[i]   <= pipe_b[i-1];
                  pipe_x[i]   <= pipe_x[i-1];
               end
            end
         end

         assign tag_vld   = pipe_vld[DUT_LAT-1];
         assign tag_a     = pipe_a[DUT_LAT-1];
         assign tag_b     = pipe_b[DUT_LAT-1];
         assign tag_exact = pipe_x[DUT_LAT-1];
      end
   endgenerate

   assign ed      = (tag_exact >= approx_r) ? (tag_exact - approx_r) : (approx_r - tag_exact);
   assign sum_ext = SW'(sum_ed) + SW'(ed);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         op_a      <= '0;
         op_b      <= '0;
         conf_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_SWEEP;
                  conf_out <= conf_in;
                  op_a     <= '0;
                  op_b     <= '0;
               end
            end
            S_SWEEP: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (last_issue) begin
                  state     <= (DUT_LAT > 0) ? S_DRAIN : S_DONE;
                  drain_cnt <= '0;
               end else begin
                  {op_a, op_b} <= {op_a, op_b} + 1'b1;
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (drain_cnt == DRAIN_LAST) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count  <= '0;
         over_count <= '0;
         sum_ed     <= '0;
         max_ed     <= '0;
         max_a      <= '0;
         max_b      <= '0;
      end else if ((state == S_IDLE) && start) begin
         err_count  <= '0;
         over_count <= '0;
         sum_ed     <= '0;
         max_ed     <= '0;
         max_a      <= '0;
         max_b      <= '0;
      end else if (tag_vld) begin
         if (ed != '0) err_count <= err_count + 1'b1;
         if (approx_r > tag_exact) over_count <= over_count + 1'b1;
         if (sum_ext > SW'({SUM_W{1'b1}})) sum_ed <= '1;
         else sum_ed <= sum_ext[SUM_W-1:0];
         // Strict compare keeps the earliest pair on ties.
         if (ed > max_ed) begin
            max_ed <= ed;
            max_a  <= tag_a;
            max_b  <= tag_b;
         end
      end
   end

endmodule
